micro_seq: RTL and testbench
============================

Name: micro_seq

Overview:
- Microprogram sequencer and writable control store that sits directly upstream of p_test.
- Holds the micro-PC (upc) and issues the current 26-bit micro-op (20-bit control field plus 6-bit next-address field) to p_test.input_micro_op.
- Takes the next address back from p_test.output_micro_op[5:0], after p_test has applied its flag/opcode branch test, and fetches the next micro-op.
- The control store is loaded through a simple write port before or between runs.

Parameters:
- UOP_W, 26, micro-op width (CTRL_W + ADDR_W).
- CTRL_W, 20, control-field width.
- ADDR_W, 6, control-store address width; depth = 2**ADDR_W = 64.
- START_ADDR, 6'h00, entry address loaded on start.
- HALT_ADDR, 6'h3F, next address that terminates the microprogram.
- CNT_W, 16, width of the issued micro-op counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins execution at START_ADDR.
- stall  in  1  hold the current micro-op and upc.
- next_valid  in  1  next_addr is valid this cycle.
- next_addr  in  ADDR_W  next micro-address from p_test.output_micro_op[5:0].
- cs_we  in  1  control-store write enable.
- cs_waddr  in  ADDR_W  write address.
- cs_wdata  in  UOP_W  write data.
- micro_op  out  UOP_W  registered micro-op, drives p_test.input_micro_op.
- upc  out  ADDR_W  address of the micro_op currently presented.
- busy  out  1  high in RUN.
- halted  out  1  high in HALT.
- uop_count  out  CNT_W  micro-ops issued since the last start (saturating).

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; micro_op=0 (NOP); upc=0; busy=0; halted=0; uop_count=0.
  - Control-store contents are not reset.
- States: IDLE, RUN, HALT.
- IDLE:
  - micro_op held at 0.
  - start=1 → at the next edge: upc<=START_ADDR, micro_op<=cs[START_ADDR], uop_count<=1, state RUN.
- RUN, evaluated in priority order each cycle:
  - 1. stall=1: hold upc, micro_op and uop_count. next_valid is ignored.
  - 2. next_valid=1 and next_addr==HALT_ADDR: micro_op<=0, upc<=HALT_ADDR, state HALT. uop_count unchanged.
  - 3. next_valid=1, other next_addr: upc<=next_addr, micro_op<=cs[next_addr], uop_count+1, saturating at all-ones.
  - 4. Otherwise: hold. This absorbs p_test's registered latency with no bubble bookkeeping here.
  - start in RUN is ignored.
- HALT:
  - Hold micro_op=0, upc=HALT_ADDR, uop_count frozen.
  - start=1 → same action as from IDLE, with uop_count restarting at 1.
- Invariant: micro_op always equals the control-store word read at upc when it was loaded. Later writes to that address do not alter the presented micro_op.
- Control store:
  - 64 x UOP_W array; synchronous write on cs_we, accepted in any state.
  - Combinational read feeds the micro_op register.
  - Same-edge write and fetch to the same address: the fetch returns the old data (read-before-write).
- Latency:
  - start → first micro_op valid: 1 cycle.
  - next_valid → new micro_op: 1 cycle.
- Reset mid-RUN: immediate async return to IDLE with NOP output. The next start refetches from START_ADDR.
- Wrap-around: next_addr is taken modulo 64 by width; there is no sequential increment.
- Outputs are registered only. There is no combinational path from next_addr to micro_op.

Decomposition:
- Shared package micro_pkg holds:
  - constants UOP_W, CTRL_W, ADDR_W, HALT_ADDR, START_ADDR;
  - the state encoding (IDLE=2'd0, RUN=2'd1, HALT=2'd2);
  - the NOP micro-op constant (all zeros).
- One sub-module: micro_cs_ram, the 64 x 26 control store with 1 synchronous write and 1 async read port, so it can be swapped for BRAM.
- FSM, upc and counter logic stay in micro_seq.

Test Plan:
- Reset check: rst_n=0 at t=0, released at 10 ns → micro_op=0, upc=0, busy=0, halted=0, uop_count=0.
- Load and run:
  - Load cs[0]=26'b00000100000000000000_000001, cs[1]=26'b00000000100000100000_000000; pulse start.
  - → micro_op=cs[0], upc=0, busy=1.
  - Drive next_valid=1 with next_addr=1 → next cycle micro_op=cs[1], upc=1, uop_count=2.
- Halt:
  - cs[2] next field = 6'h3F; feed next_addr=2, then next_addr=6'h3F.
  - → halted=1, busy=0, micro_op=0, upc=6'h3F, uop_count=3.
  - start → restarts at cs[0] with uop_count=1.
- Stall priority: stall=1 and next_valid=1 with next_addr=5 for 3 cycles → upc and micro_op unchanged. Release stall → loads cs[5].
- Write collision: in RUN, cs_we=1 with cs_waddr=4, data 26'h3FFFFFF, on the same edge as a fetch of addr 4 → micro_op = old cs[4]. A later fetch of 4 returns 26'h3FFFFFF.
- Reset mid-run: assert rst_n=0 while upc=1 → outputs go to reset values asynchronously. Control-store data is retained; verify by start and fetching cs[0] unchanged.

Source files
------------

// File: rtl/micro_pkg.sv
// micro_pkg: shared widths, addresses and state encoding for the microprogram sequencer
package micro_pkg;
    localparam int CTRL_W = 20;
    localparam int ADDR_W = 6;
    localparam int UOP_W  = CTRL_W + ADDR_W;
    localparam int CNT_W  = 16;
    localparam logic [ADDR_W-1:0] START_ADDR = 6'h00;
    localparam logic [ADDR_W-1:0] HALT_ADDR  = 6'h3F;
    localparam logic [UOP_W-1:0]  NOP        = '0;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;
endpackage

// File: rtl/micro_cs_ram.sv
// micro_cs_ram: 64-entry writable control store, one sync write port and one async read port
module micro_cs_ram
    import micro_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [UOP_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [UOP_W-1:0]  rdata
);
    logic [UOP_W-1:0] mem [2**ADDR_W];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/micro_seq.sv
// micro_seq: micro-PC sequencer issuing control-store words and following next addresses fed back from p_test
module micro_seq
    import micro_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    input  logic              next_valid,
    input  logic [ADDR_W-1:0] next_addr,
    input  logic              cs_we,
    input  logic [ADDR_W-1:0] cs_waddr,
    input  logic [UOP_W-1:0]  cs_wdata,
    output logic [UOP_W-1:0]  micro_op,
    output logic [ADDR_W-1:0] upc,
    output logic              busy,
    output logic              halted,
    output logic [CNT_W-1:0]  uop_count
);
    state_t            state, state_n;
    logic [ADDR_W-1:0] upc_n, raddr;
    logic [UOP_W-1:0]  op_n, rdata;
    logic [CNT_W-1:0]  cnt_n;

    micro_cs_ram u_cs (
        .clk   (clk),
        .we    (cs_we),
        .waddr (cs_waddr),
        .wdata (cs_wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    // Outside RUN the only possible fetch is the entry word
    assign raddr  = (state == RUN) ? next_addr : START_ADDR;
    assign busy   = state == RUN;
    assign halted = state == HALT;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            upc       <= '0;
            micro_op  <= NOP;
            uop_count <= '0;
        end else begin
            state     <= state_n;
            upc       <= upc_n;
            micro_op  <= op_n;
            uop_count <= cnt_n;
        end

    always_comb begin
        state_n = state;
        upc_n   = upc;
        op_n    = micro_op;
        cnt_n   = uop_count;
        case (state)
            IDLE, HALT: if (start) begin
                state_n = RUN;
                upc_n   = START_ADDR;
                op_n    = rdata;
                cnt_n   = CNT_W'(1);
            end
            RUN: if (!stall && next_valid) begin
                if (next_addr == HALT_ADDR) begin
                    state_n = HALT;
                    upc_n   = HALT_ADDR;
                    op_n    = NOP;
                end else begin
                    upc_n = next_addr;
                    op_n  = rdata;
                    cnt_n = &uop_count ? uop_count : uop_count + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_micro_seq.sv
// tb_micro_seq: directed plan plus random traffic checked against a behavioural sequencer model
module tb_micro_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, stall = 1'b0, next_valid = 1'b0, cs_we = 1'b0;
    logic [5:0]  next_addr = '0, cs_waddr = '0, upc;
    logic [25:0] cs_wdata = '0, micro_op;
    logic        busy, halted;
    logic [15:0] uop_count;

    int checks = 0, failures = 0;

    logic [25:0] cs_m [64];
    bit          m_run = 0, m_halt = 0;
    logic [5:0]  m_upc = '0;
    logic [25:0] m_op = '0;
    int          m_cnt = 0;

    micro_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stall      (stall),
        .next_valid (next_valid),
        .next_addr  (next_addr),
        .cs_we      (cs_we),
        .cs_waddr   (cs_waddr),
        .cs_wdata   (cs_wdata),
        .micro_op   (micro_op),
        .upc        (upc),
        .busy       (busy),
        .halted     (halted),
        .uop_count  (uop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".micro_op"}, 32'(micro_op), 32'(m_op));
        chk({tag, ".upc"}, 32'(upc), 32'(m_upc));
        chk({tag, ".busy"}, 32'(busy), 32'(m_run));
        chk({tag, ".halted"}, 32'(halted), 32'(m_halt));
        chk({tag, ".uop_count"}, 32'(uop_count), 32'(m_cnt));
    endtask

    task automatic drive(input bit st, input bit sl, input bit nv, input logic [5:0] na,
                         input bit we, input logic [5:0] wa, input logic [25:0] wd);
        start = st; stall = sl; next_valid = nv; next_addr = na;
        cs_we = we; cs_waddr = wa; cs_wdata = wd;
    endtask

    task automatic model_reset();
        m_run = 0; m_halt = 0; m_upc = '0; m_op = '0; m_cnt = 0;
    endtask

    // Fetches see the store as it was before this edge's write
    task automatic cyc(input string tag);
        bit          n_run, n_halt;
        logic [5:0]  n_upc;
        logic [25:0] n_op;
        int          n_cnt;
        n_run = m_run; n_halt = m_halt; n_upc = m_upc; n_op = m_op; n_cnt = m_cnt;
        if (!m_run) begin
            if (start) begin
                n_run = 1; n_halt = 0; n_upc = 6'h00; n_op = cs_m[0]; n_cnt = 1;
            end
        end else if (!stall && next_valid) begin
            if (next_addr == 6'h3F) begin
                n_run = 0; n_halt = 1; n_upc = 6'h3F; n_op = '0;
            end else begin
                n_upc = next_addr; n_op = cs_m[next_addr];
                n_cnt = (m_cnt == 65535) ? m_cnt : m_cnt + 1;
            end
        end
        if (cs_we) cs_m[cs_waddr] = cs_wdata;
        @(posedge clk);
        #1;
        m_run = n_run; m_halt = n_halt; m_upc = n_upc; m_op = n_op; m_cnt = n_cnt;
        chk_all(tag);
    endtask

    initial begin
        #10 rst_n = 1'b1;
        #1 chk_all("reset");
        for (int i = 0; i < 64; i++) begin
            logic [25:0] w;
            w = 26'($urandom);
            if (i == 0) w = 26'b00000100000000000000_000001;
            if (i == 1) w = 26'b00000000100000100000_000000;
            if (i == 2) w = {20'h12345, 6'h3F};
            drive(0, 0, 0, '0, 1, 6'(i), w);
            cyc("load");
        end
        drive(1, 0, 0, '0, 0, '0, '0);   cyc("start");
        drive(0, 0, 1, 6'd1, 0, '0, '0); cyc("fetch1");
        drive(0, 0, 1, 6'd2, 0, '0, '0); cyc("fetch2");
        drive(0, 0, 1, 6'h3F, 0, '0, '0); cyc("halt");
        drive(0, 0, 0, '0, 0, '0, '0);   cyc("halt_hold");
        drive(1, 0, 0, '0, 0, '0, '0);   cyc("restart");
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 6'd5, 0, '0, '0); cyc("stall");
        end
        drive(0, 0, 1, 6'd5, 0, '0, '0); cyc("unstall");
        drive(1, 0, 0, '0, 0, '0, '0);   cyc("start_in_run");
        drive(0, 0, 1, 6'd4, 1, 6'd4, 26'h3FFFFFF); cyc("collide");
        drive(0, 0, 1, 6'd4, 0, '0, '0); cyc("refetch4");
        drive(0, 0, 1, 6'd1, 0, '0, '0); cyc("to1");
        drive(0, 0, 0, '0, 0, '0, '0);
        #2 rst_n = 1'b0;
        model_reset();
        #1 chk_all("async_reset");
        #2 rst_n = 1'b1;
        drive(1, 0, 0, '0, 0, '0, '0);   cyc("post_reset_start");
        for (int i = 0; i < 600; i++) begin
            logic [5:0] na;
            na = ($urandom_range(0, 15) == 0) ? 6'h3F : 6'($urandom);
            drive($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                  na, $urandom_range(0, 4) == 0, 6'($urandom), 26'($urandom));
            cyc("rand");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
